// File: rtl/turbo_enc_8bit_if.sv
// turbo_enc_8bit_if: pin bundle of the byte-wide turbo encoder tile.
interface turbo_enc_8bit_if;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    modport master (output ui_in, output uio_in, input uo_out);
    modport slave (input ui_in, input uio_in, output uo_out);
endinterface

// File: rtl/turbo_enc_8bit.sv
// turbo_enc_8bit: two trellis-terminated 8-state RSC encoders (natural and interleaved order)
// over one 8-bit block per start strobe, streaming x/z/z'/x' one step per clock.
module turbo_enc_8bit (
    input logic clk,
    input logic rst,
    turbo_enc_8bit_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DATA = 2'd1;
    localparam logic [1:0] TAIL = 2'd2;
    logic [1:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] data_q, data_d;
    logic [2:0] e1_q, e1_d, e2_q, e2_d;
    logic pend_q, pend_d;
    logic [7:0] uo_q, uo_d;
    logic [2:0] pi;
    logic run, u1, u2, f1, f2, p1, p2;
    logic unused_ok;
    assign unused_ok = &{1'b0, bus.uio_in[7:1]};
    assign bus.uo_out = uo_q;
    // Encoder state vectors are {s3, s2, s1}; in TAIL u = s2^s3 forces the feedback to 0.
    always_comb begin
        pi = cnt_q * 3'd5 + 3'd3;
        run = state_q == DATA || state_q == TAIL;
        u1 = state_q == DATA ? data_q[cnt_q] : e1_q[1] ^ e1_q[2];
        u2 = state_q == DATA ? data_q[pi] : e2_q[1] ^ e2_q[2];
        f1 = u1 ^ e1_q[1] ^ e1_q[2];
        f2 = u2 ^ e2_q[1] ^ e2_q[2];
        p1 = f1 ^ e1_q[0] ^ e1_q[2];
        p2 = f2 ^ e2_q[0] ^ e2_q[2];
        state_d = state_q;
        cnt_d = cnt_q;
        data_d = data_q;
        e1_d = e1_q;
        e2_d = e2_q;
        pend_d = 1'b0;
        uo_d = 8'h00;
        if (run) begin
            e1_d = {e1_q[1:0], f1};
            e2_d = {e2_q[1:0], f2};
            cnt_d = cnt_q + 3'd1;
            uo_d = {1'b0, u2, 1'b0, 2'b11, p2, p1, u1};
            if (state_q == DATA && cnt_q == 3'd7) begin
                state_d = TAIL;
                cnt_d = 3'd0;
            end
            if (state_q == TAIL && cnt_q == 3'd2) begin
                state_d = IDLE;
                cnt_d = 3'd0;
                pend_d = 1'b1;
            end
        end else begin
            // Done follows the last tail step by one cycle and may coincide with a new load.
            uo_d[5] = pend_q;
            if (bus.uio_in[0]) begin
                data_d = bus.ui_in;
                e1_d = 3'd0;
                e2_d = 3'd0;
                cnt_d = 3'd0;
                state_d = DATA;
                uo_d[4] = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= 3'd0;
            data_q <= 8'h00;
            e1_q <= 3'd0;
            e2_q <= 3'd0;
            pend_q <= 1'b0;
            uo_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            data_q <= data_d;
            e1_q <= e1_d;
            e2_q <= e2_d;
            pend_q <= pend_d;
            uo_q <= uo_d;
        end
    end
endmodule

// File: tb/tb_turbo_enc_8bit.sv
// tb_turbo_enc_8bit: table vectors, random blocks vs. a behavioural turbo-code model,
// back-to-back and mid-block reset sequences.
module tb_turbo_enc_8bit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    turbo_enc_8bit_if bus ();
    turbo_enc_8bit dut (.clk(clk), .rst(rst), .bus(bus));
    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] cap [0:13];
    logic [7:0] ref_o [0:13];
    typedef struct {
        logic [7:0] d;
        int idx;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs [9];
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, got, exp);
        end
    endtask
    // Expected uo_out for load cycle, 11 code steps, done cycle and the idle cycle after.
    task automatic build_ref(input logic [7:0] d);
        int pt [8];
        int a, b, ua, ub, fa, fb, pa, pb;
        pt = '{3, 0, 5, 2, 7, 4, 1, 6};
        a = 0;
        b = 0;
        ref_o[0] = 8'h10;
        for (int t = 0; t < 11; t++) begin
            ua = t < 8 ? int'(d[t]) : ((a >> 1) ^ (a >> 2)) & 1;
            ub = t < 8 ? int'(d[pt[t]]) : ((b >> 1) ^ (b >> 2)) & 1;
            fa = (ua ^ (a >> 1) ^ (a >> 2)) & 1;
            fb = (ub ^ (b >> 1) ^ (b >> 2)) & 1;
            pa = (fa ^ a ^ (a >> 2)) & 1;
            pb = (fb ^ b ^ (b >> 2)) & 1;
            ref_o[t + 1] = 8'(ua | (pa << 1) | (pb << 2) | 8'h18 | (ub << 6));
            a = ((a << 1) | fa) & 7;
            b = ((b << 1) | fb) & 7;
        end
        ref_o[12] = 8'h20;
        ref_o[13] = 8'h00;
    endtask
    task automatic run_block(input logic [7:0] d, input bit repulse);
        bus.ui_in = d;
        bus.uio_in = 8'h01;
        step();
        cap[0] = bus.uo_out;
        for (int i = 1; i < 14; i++) begin
            bus.uio_in = {7'($urandom), repulse && i <= 11 && ($urandom % 2 == 1)};
            bus.ui_in = 8'($urandom);
            step();
            cap[i] = bus.uo_out;
        end
        bus.uio_in = 8'h00;
    endtask
    task automatic check_block(input string name);
        for (int i = 0; i < 14; i++) chk($sformatf("%s[%0d]", name, i), cap[i], ref_o[i]);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
    initial begin
        logic [7:0] d;
        vecs[0] = '{8'h00, 0, 8'h10};
        vecs[1] = '{8'h00, 1, 8'h18};
        vecs[2] = '{8'h00, 11, 8'h18};
        vecs[3] = '{8'h00, 12, 8'h20};
        vecs[4] = '{8'h00, 13, 8'h00};
        vecs[5] = '{8'h01, 1, 8'h1B};
        vecs[6] = '{8'h01, 2, 8'h5E};
        vecs[7] = '{8'hFF, 1, 8'h5F};
        vecs[8] = '{8'hFF, 2, 8'h59};
        bus.ui_in = 8'h00;
        bus.uio_in = 8'h00;
        repeat (3) step();
        chk("in_reset", bus.uo_out, 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("idle_after_reset", bus.uo_out, 8'h00);
        end
        foreach (vecs[i]) begin
            run_block(vecs[i].d, 1'b0);
            chk($sformatf("vec%0d_d%02h_c%0d", i, vecs[i].d, vecs[i].idx), cap[vecs[i].idx], vecs[i].exp);
        end
        build_ref(8'h01);
        run_block(8'h01, 1'b0);
        check_block("blk01");
        chk("enc1_state_after_tail", {5'b0, dut.e1_q}, 8'h00);
        chk("enc2_state_after_tail", {5'b0, dut.e2_q}, 8'h00);
        for (int n = 0; n < 20; n++) begin
            d = 8'($urandom);
            build_ref(d);
            run_block(d, 1'b1);
            check_block($sformatf("rand%0d_%02h", n, d));
        end
        build_ref(8'hA5);
        bus.ui_in = 8'hA5;
        bus.uio_in = 8'h01;
        step();
        chk("b2b_a5[0]", bus.uo_out, ref_o[0]);
        for (int i = 1; i < 12; i++) begin
            bus.uio_in = 8'h00;
            bus.ui_in = 8'($urandom);
            step();
            chk($sformatf("b2b_a5[%0d]", i), bus.uo_out, ref_o[i]);
        end
        bus.ui_in = 8'h3C;
        bus.uio_in = 8'h01;
        step();
        chk("b2b_done_and_load", bus.uo_out, 8'h30);
        build_ref(8'h3C);
        bus.uio_in = 8'h00;
        for (int i = 1; i < 14; i++) begin
            step();
            chk($sformatf("b2b_3c[%0d]", i), bus.uo_out, ref_o[i]);
        end
        build_ref(8'h96);
        bus.ui_in = 8'h96;
        bus.uio_in = 8'h01;
        step();
        bus.uio_in = 8'h00;
        repeat (4) step();
        chk("abort_step3", bus.uo_out, ref_o[4]);
        rst = 1'b1;
        step();
        chk("abort_reset_out", bus.uo_out, 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step();
            chk("abort_no_done", bus.uo_out, 8'h00);
        end
        d = 8'($urandom);
        build_ref(d);
        run_block(d, 1'b0);
        check_block("after_abort");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
